reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 97 +++++++++
 tb/tb_reg_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter (ALU writeback vs. memory load).
// Round-robin on ties, registered grant with a one-cycle ack, plus decode-stage hazard flags.
module reg_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqA,
    input  logic [4:0]  addrA,
    input  logic [31:0] dataA,
    output logic        ackA,
    input  logic        reqB,
    input  logic [4:0]  addrB,
    input  logic [31:0] dataB,
    output logic        ackB,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    input  logic [4:0]  readRegister1,
    input  logic [4:0]  readRegister2,
    output logic        hazard1,
    output logic        hazard2
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic        last_grant_q, last_grant_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_register_q, write_register_d;
    logic [31:0] write_data_q, write_data_d;

    logic elig_a, elig_b, grant_a, grant_b;

    // A requester sitting in its ack cycle is not eligible, so one request yields one grant.
    always_comb begin
        elig_a  = reqA & ~ack_a_q;
        elig_b  = reqB & ~ack_b_q;
        grant_a = elig_a & (~elig_b | (last_grant_q == GRANT_B));
        grant_b = elig_b & ~grant_a;

        last_grant_d     = last_grant_q;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        ack_a_d          = grant_a;
        ack_b_d          = grant_b;
        reg_write_d      = 1'b0;

        if (grant_a) begin
            last_grant_d     = GRANT_A;
            write_register_d = addrA;
            write_data_d     = dataA;
            reg_write_d      = (addrA != 5'd0);
        end else if (grant_b) begin
            last_grant_d     = GRANT_B;
            write_register_d = addrB;
            write_data_d     = dataB;
            reg_write_d      = (addrB != 5'd0);
        end
    end

    // Reset wins over any grant on the same edge and cancels a write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q     <= GRANT_B;
            ack_a_q          <= 1'b0;
            ack_b_q          <= 1'b0;
            reg_write_q      <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= 32'd0;
        end else begin
            last_grant_q     <= last_grant_d;
            ack_a_q          <= ack_a_d;
            ack_b_q          <= ack_b_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign ackA          = ack_a_q;
    assign ackB          = ack_b_q;
    assign regWrite      = reg_write_q;
    assign writeRegister = write_register_q;
    assign writeData     = write_data_q;

    assign hazard1 = (readRegister1 != 5'd0) &&
                     ((reqA && (addrA == readRegister1)) ||
                      (reqB && (addrB == readRegister1)) ||
                      (reg_write_q && (write_register_q == readRegister1)));

    assign hazard2 = (readRegister2 != 5'd0) &&
                     ((reqA && (addrA == readRegister2)) ||
                      (reqB && (addrB == readRegister2)) ||
                      (reg_write_q && (write_register_q == readRegister2)));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqA, reqB;
    logic [4:0]  addrA, addrB;
    logic [31:0] dataA, dataB;
    logic        ackA, ackB, regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [4:0]  readRegister1, readRegister2;
    logic        hazard1, hazard2;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reqA = 1'b0; reqB = 1'b0;
        addrA = 5'd0; addrB = 5'd0; dataA = 32'd0; dataB = 32'd0;
        readRegister1 = 5'd0; readRegister2 = 5'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqA = 1'b1; addrA = 5'd9; dataA = 32'h5555_AAAA;
        reqB = 1'b0; addrB = 5'd0; dataB = 32'd0;
        readRegister1 = 5'd0; readRegister2 = 5'd0;
        tick();
        tick();
        checks++; if (ackA !== 1'b0) begin errors++; $display("FAIL reset_ackA got %b want 0", ackA); end
        checks++; if (ackB !== 1'b0) begin errors++; $display("FAIL reset_ackB got %b want 0", ackB); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got %b want 0", regWrite); end
        checks++; if (writeRegister !== 5'd0) begin errors++; $display("FAIL reset_writeRegister got %0d want 0", writeRegister); end
        checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData got %h want 0", writeData); end
        reqA = 1'b0;
        reset = 1'b0;
        $display("reset: ack/regWrite/writeRegister/writeData observed cleared");
    endtask

    task automatic test_single_a();
        do_reset();
        reqA = 1'b1; addrA = 5'd5; dataA = 32'hDEAD_BEEF; readRegister1 = 5'd5; readRegister2 = 5'd6;
        #1;
        checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL single_hazard1_pending got %b want 1", hazard1); end
        checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL single_hazard2_nomatch got %b want 0", hazard2); end
        tick();
        checks++; if (ackA !== 1'b1) begin errors++; $display("FAIL single_ackA got %b want 1", ackA); end
        checks++; if (ackB !== 1'b0) begin errors++; $display("FAIL single_ackB got %b want 0", ackB); end
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL single_regWrite got %b want 1", regWrite); end
        checks++; if (writeRegister !== 5'd5) begin errors++; $display("FAIL single_writeRegister got %0d want 5", writeRegister); end
        checks++; if (writeData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_writeData got %h want deadbeef", writeData); end
        reqA = 1'b0; addrA = 5'd0; dataA = 32'd0;
        #1;
        checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL single_hazard1_inflight got %b want 1", hazard1); end
        $display("single A: wr=%0d data=%h", writeRegister, writeData);
        tick();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_regWrite_fall got %b want 0", regWrite); end
        checks++; if (ackA !== 1'b0) begin errors++; $display("FAIL single_ackA_fall got %b want 0", ackA); end
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL single_hazard1_clear got %b want 0", hazard1); end
        checks++; if (writeRegister !== 5'd5) begin errors++; $display("FAIL single_hold_writeRegister got %0d want 5", writeRegister); end
        checks++; if (writeData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold_writeData got %h want deadbeef", writeData); end
    endtask

    task automatic test_alternate();
        do_reset();
        reqA = 1'b1; addrA = 5'd3; dataA = 32'h0000_00A0;
        reqB = 1'b1; addrB = 5'd4; dataB = 32'h0000_00B0;
        readRegister2 = 5'd4;
        #1;
        checks++; if (hazard2 !== 1'b1) begin errors++; $display("FAIL alt_hazard2_reqB got %b want 1", hazard2); end
        for (int i = 0; i < 4; i++) begin
            logic exp_a;
            exp_a = (i % 2 == 0);
            tick();
            checks++; if (ackA !== exp_a) begin errors++; $display("FAIL alt_ackA[%0d] got %b want %b", i, ackA, exp_a); end
            checks++; if (ackB !== !exp_a) begin errors++; $display("FAIL alt_ackB[%0d] got %b want %b", i, ackB, !exp_a); end
            checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL alt_regWrite[%0d] got %b want 1", i, regWrite); end
            checks++; if (writeRegister !== (exp_a ? 5'd3 : 5'd4)) begin errors++; $display("FAIL alt_writeRegister[%0d] got %0d want %0d", i, writeRegister, exp_a ? 3 : 4); end
            checks++; if (writeData !== (exp_a ? 32'hA0 : 32'hB0)) begin errors++; $display("FAIL alt_writeData[%0d] got %h want %h", i, writeData, exp_a ? 32'hA0 : 32'hB0); end
            $display("alternate %0d: ackA=%b ackB=%b wr=%0d data=%h", i, ackA, ackB, writeRegister, writeData);
        end
        reqA = 1'b0; reqB = 1'b0;
    endtask

    task automatic test_b_only();
        do_reset();
        reqB = 1'b1; addrB = 5'd10; dataB = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            logic       exp_w;
            logic [4:0] exp_reg;
            exp_w   = (i % 2 == 0);
            exp_reg = (i < 2) ? 5'd10 : 5'd11;
            tick();
            checks++; if (regWrite !== exp_w) begin errors++; $display("FAIL bonly_regWrite[%0d] got %b want %b", i, regWrite, exp_w); end
            checks++; if (ackB !== exp_w) begin errors++; $display("FAIL bonly_ackB[%0d] got %b want %b", i, ackB, exp_w); end
            checks++; if (writeRegister !== exp_reg) begin errors++; $display("FAIL bonly_writeRegister[%0d] got %0d want %0d", i, writeRegister, exp_reg); end
            $display("B only %0d: ackB=%b regWrite=%b wr=%0d", i, ackB, regWrite, writeRegister);
            if (ackB) begin
                addrB = addrB + 5'd1;
                dataB = dataB + 32'd1;
            end
        end
        reqB = 1'b0;
    endtask

    task automatic test_zero_addr();
        do_reset();
        reqA = 1'b1; addrA = 5'd0; dataA = 32'h0000_1234; readRegister1 = 5'd0;
        #1;
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL zero_hazard1_pending got %b want 0", hazard1); end
        tick();
        checks++; if (ackA !== 1'b1) begin errors++; $display("FAIL zero_ackA got %b want 1", ackA); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL zero_regWrite got %b want 0", regWrite); end
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL zero_hazard1 got %b want 0", hazard1); end
        checks++; if (writeData !== 32'h1234) begin errors++; $display("FAIL zero_writeData got %h want 1234", writeData); end
        $display("zero addr: ackA=%b regWrite=%b", ackA, regWrite);
        reqA = 1'b0;
    endtask

    task automatic test_same_addr();
        do_reset();
        reqA = 1'b1; addrA = 5'd7; dataA = 32'h11;
        reqB = 1'b1; addrB = 5'd7; dataB = 32'h22;
        readRegister2 = 5'd7;
        tick();
        checks++; if (ackA !== 1'b1) begin errors++; $display("FAIL same_first_ackA got %b want 1", ackA); end
        checks++; if (writeData !== 32'h11) begin errors++; $display("FAIL same_first_data got %h want 11", writeData); end
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL same_first_regWrite got %b want 1", regWrite); end
        $display("same addr 1: ackA=%b wr=%0d data=%h", ackA, writeRegister, writeData);
        reqA = 1'b0;
        tick();
        checks++; if (ackB !== 1'b1) begin errors++; $display("FAIL same_second_ackB got %b want 1", ackB); end
        checks++; if (writeRegister !== 5'd7) begin errors++; $display("FAIL same_second_reg got %0d want 7", writeRegister); end
        checks++; if (writeData !== 32'h22) begin errors++; $display("FAIL same_second_data got %h want 22", writeData); end
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL same_second_regWrite got %b want 1", regWrite); end
        $display("same addr 2: ackB=%b wr=%0d data=%h", ackB, writeRegister, writeData);
        reqB = 1'b0;
        tick();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL same_idle_regWrite got %b want 0", regWrite); end
        checks++; if (writeData !== 32'h22) begin errors++; $display("FAIL same_final_data got %h want 22", writeData); end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        reqA = 1'b1; addrA = 5'd6; dataA = 32'h0000_CAFE;
        tick();
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL rif_grant_regWrite got %b want 1", regWrite); end
        reset = 1'b1;
        tick();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL rif_cancel_regWrite got %b want 0", regWrite); end
        checks++; if (ackA !== 1'b0) begin errors++; $display("FAIL rif_cancel_ackA got %b want 0", ackA); end
        checks++; if (writeRegister !== 5'd0) begin errors++; $display("FAIL rif_cancel_reg got %0d want 0", writeRegister); end
        tick();
        checks++; if (ackA !== 1'b0) begin errors++; $display("FAIL rif_held_ackA got %b want 0", ackA); end
        reset = 1'b0;
        tick();
        checks++; if (ackA !== 1'b1) begin errors++; $display("FAIL rif_reserve_ackA got %b want 1", ackA); end
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL rif_reserve_regWrite got %b want 1", regWrite); end
        checks++; if (writeRegister !== 5'd6) begin errors++; $display("FAIL rif_reserve_reg got %0d want 6", writeRegister); end
        checks++; if (writeData !== 32'hCAFE) begin errors++; $display("FAIL rif_reserve_data got %h want cafe", writeData); end
        $display("reset in flight: re-served wr=%0d data=%h", writeRegister, writeData);
        reqA = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_alternate();
        test_b_only();
        test_zero_addr();
        test_same_addr();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (ackA === 1'b1 && ackB === 1'b1) begin
            errors++;
            $display("FAIL dual_ack got ackA=%b ackB=%b want at most one", ackA, ackB);
        end
    end

endmodule
